// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and state encodings for the sequential ALU.
package alu_pkg;

  localparam int unsigned OP_BITS = 4;

  localparam logic [OP_BITS-1:0] OP_ADD = 4'b0001;
  localparam logic [OP_BITS-1:0] OP_SUB = 4'b0010;
  localparam logic [OP_BITS-1:0] OP_AND = 4'b0011;
  localparam logic [OP_BITS-1:0] OP_OR  = 4'b0100;
  localparam logic [OP_BITS-1:0] OP_XOR = 4'b0101;
  localparam logic [OP_BITS-1:0] OP_MUL = 4'b0110;
  localparam logic [OP_BITS-1:0] OP_SHL = 4'b0111;
  localparam logic [OP_BITS-1:0] OP_SHR = 4'b1000;
  localparam logic [OP_BITS-1:0] OP_NOT = 4'b1001;
  localparam logic [OP_BITS-1:0] OP_EQ  = 4'b1010;
  localparam logic [OP_BITS-1:0] OP_NE  = 4'b1011;
  localparam logic [OP_BITS-1:0] OP_GT  = 4'b1100;
  localparam logic [OP_BITS-1:0] OP_LT  = 4'b1101;
  localparam logic [OP_BITS-1:0] OP_DIV = 4'b1110;

  localparam int unsigned FLG_ZERO = 0;
  localparam int unsigned FLG_NEG  = 1;
  localparam int unsigned FLG_OVF  = 2;
  localparam int unsigned FLG_DBZ  = 3;
  localparam int unsigned FLG_W    = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIVIDE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

endpackage

// File: rtl/alu_seq_div.sv
// Unsigned W-step restoring divider; the first step runs on the start edge,
// so done pulses W-1 cycles after start with quotient/remainder final.
module alu_seq_div #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]  d_q;
  logic [CW-1:0] cnt;
  logic [W-1:0]  src_q, src_r, src_d, q_nx, r_nx;
  logic [W:0]    trial, dvs;

  // One restoring step, fed from the inputs on start or from the registers
  always_comb begin
    src_q = start ? dividend : quotient;
    src_r = start ? '0 : remainder;
    src_d = start ? divisor : d_q;
    trial = {src_r, src_q[W-1]};
    dvs   = {1'b0, src_d};
    r_nx  = trial[W-1:0];
    q_nx  = {src_q[W-2:0], 1'b0};
    if (trial >= dvs) begin
      r_nx    = W'(trial - dvs);
      q_nx[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      quotient  <= '0;
      remainder <= '0;
      d_q       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quotient  <= q_nx;
        remainder <= r_nx;
        d_q       <= divisor;
        cnt       <= CW'(1);
        busy      <= 1'b1;
      end else if (busy) begin
        quotient  <= q_nx;
        remainder <= r_nx;
        cnt       <= cnt + CW'(1);
        if (cnt == CW'(W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked signed ALU: single-cycle ops plus an iterative signed divide,
// 2W-bit result and {dbz, ovf, neg, zero} flags held until consumed.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned W   = 4,
  parameter int unsigned OPW = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  op,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  result,
  output logic [FLG_W-1:0] flags
);

  localparam int unsigned RW = 2 * W;
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W - 1){1'b0}}};

  logic [1:0]             state, state_n;
  logic [W-1:0]           a_q, b_q;
  logic [RW-1:0]          result_n, alu_res;
  logic [FLG_W-1:0]       flags_n, alu_flg;
  logic                   alu_def_c, is_div_c, div_start_c, div_busy, div_done;
  logic signed [RW-1:0]   sa_c, sb_c;
  logic [W-1:0]           sum_w_c, dif_w_c;
  logic [W-1:0]           a_mag_c, b_mag_c, quo_mag, rem_mag, quo_c, rem_c;

  assign sa_c     = {{W{a[W-1]}}, a};
  assign sb_c     = {{W{b[W-1]}}, b};
  assign sum_w_c  = a + b;
  assign dif_w_c  = a - b;
  assign is_div_c = (op == OPW'(OP_DIV)) && (b != '0);
  assign a_mag_c  = a[W-1] ? W'(-a) : a;
  assign b_mag_c  = b[W-1] ? W'(-b) : b;
  assign quo_c    = (a_q[W-1] ^ b_q[W-1]) ? W'(-quo_mag) : quo_mag;
  assign rem_c    = a_q[W-1] ? W'(-rem_mag) : rem_mag;

  // Single-cycle datapath, including the divide-by-zero shortcut
  always_comb begin
    alu_res   = '0;
    alu_flg   = '0;
    alu_def_c = 1'b1;
    case (op)
      OPW'(OP_ADD): begin
        alu_res          = sa_c + sb_c;
        alu_flg[FLG_OVF] = (a[W-1] == b[W-1]) && (sum_w_c[W-1] != a[W-1]);
      end
      OPW'(OP_SUB): begin
        alu_res          = sa_c - sb_c;
        alu_flg[FLG_OVF] = (a[W-1] != b[W-1]) && (dif_w_c[W-1] != a[W-1]);
      end
      OPW'(OP_AND): alu_res = {{W{1'b0}}, a & b};
      OPW'(OP_OR):  alu_res = {{W{1'b0}}, a | b};
      OPW'(OP_XOR): alu_res = {{W{1'b0}}, a ^ b};
      OPW'(OP_MUL): alu_res = sa_c * sb_c;
      OPW'(OP_SHL): alu_res = {{(W - 1){1'b0}}, a, 1'b0};
      OPW'(OP_SHR): alu_res = sa_c >>> 1;
      OPW'(OP_NOT): alu_res = {{W{1'b0}}, ~a};
      OPW'(OP_EQ):  alu_res = {{(RW - 1){1'b0}}, (a == b)};
      OPW'(OP_NE):  alu_res = {{(RW - 1){1'b0}}, (a != b)};
      OPW'(OP_GT):  alu_res = {{(RW - 1){1'b0}}, ($signed(a) > $signed(b))};
      OPW'(OP_LT):  alu_res = {{(RW - 1){1'b0}}, ($signed(a) < $signed(b))};
      OPW'(OP_DIV): begin
        alu_def_c        = 1'b0;
        alu_res          = {a, {W{1'b1}}};
        alu_flg[FLG_DBZ] = 1'b1;
        alu_flg[FLG_NEG] = 1'b1;
      end
      default:      alu_def_c = 1'b0;
    endcase
    if (alu_def_c) begin
      alu_flg[FLG_ZERO] = (alu_res == '0);
      alu_flg[FLG_NEG]  = alu_res[RW-1];
    end
  end

  // Next-state and result/flag update
  always_comb begin
    state_n     = state;
    result_n    = result;
    flags_n     = flags;
    div_start_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_div_c) begin
            if (!div_busy) begin
              state_n     = ST_DIVIDE;
              div_start_c = 1'b1;
            end
          end else begin
            state_n  = ST_DONE;
            result_n = alu_res;
            flags_n  = alu_flg;
          end
        end
      end
      ST_DIVIDE: begin
        if (div_done) begin
          state_n           = ST_DONE;
          result_n          = {rem_c, quo_c};
          flags_n           = '0;
          flags_n[FLG_ZERO] = ({rem_c, quo_c} == '0);
          flags_n[FLG_NEG]  = quo_c[W-1];
          flags_n[FLG_OVF]  = (a_q == MIN_VAL) && (b_q == '1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      state     <= state_n;
      in_ready  <= (state_n == ST_IDLE);
      out_valid <= (state_n == ST_DONE);
      result    <= result_n;
      flags     <= flags_n;
      if (div_start_c) begin
        a_q <= a;
        b_q <= b;
      end
    end
  end

  alu_seq_div #(.W(W)) u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (div_start_c),
    .dividend  (a_mag_c),
    .divisor   (b_mag_c),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (quo_mag),
    .remainder (rem_mag)
  );

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at W=4: directed cases with literal expectations plus a
// randomized run checked every cycle against a transaction-level model.
module tb_alu_seq;

  localparam int unsigned W = 4;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   result;
  logic [3:0]   flags;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  alu_seq #(.W(W), .OPW(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: returns {flags[3:0], result[7:0]} from plain integer arithmetic
  function automatic logic [11:0] ref_alu(input logic [3:0] o, input logic [3:0] x, input logic [3:0] y);
    int sa, sb, r, q, rm;
    logic [7:0] res;
    logic [3:0] f;
    bit def;
    sa = int'(x); if (x[3]) sa -= 16;
    sb = int'(y); if (y[3]) sb -= 16;
    res = '0; f = '0; def = 1;
    case (o)
      4'h1: begin r = sa + sb; res = 8'(r); f[2] = (r > 7) || (r < -8); end
      4'h2: begin r = sa - sb; res = 8'(r); f[2] = (r > 7) || (r < -8); end
      4'h3: res = {4'h0, x & y};
      4'h4: res = {4'h0, x | y};
      4'h5: res = {4'h0, x ^ y};
      4'h6: res = 8'(sa * sb);
      4'h7: res = 8'(int'(x) * 2);
      4'h8: res = 8'(sa >>> 1);
      4'h9: res = {4'h0, ~x};
      4'hA: res = (sa == sb) ? 8'd1 : 8'd0;
      4'hB: res = (sa != sb) ? 8'd1 : 8'd0;
      4'hC: res = (sa > sb)  ? 8'd1 : 8'd0;
      4'hD: res = (sa < sb)  ? 8'd1 : 8'd0;
      4'hE: begin
        def = 0;
        if (sb == 0) begin
          res = {x, 4'hF};
          f   = 4'b1010;
        end else begin
          q  = sa / sb;
          rm = sa % sb;
          res  = {4'(rm), 4'(q)};
          f[2] = (q > 7);
          f[1] = res[3];
          f[0] = (res == 8'd0);
        end
      end
      default: def = 0;
    endcase
    if (def) begin
      f[0] = (res == 8'd0);
      f[1] = res[7];
    end
    return {f, res};
  endfunction

  // Transaction-level model: ready/valid and a countdown to completion
  logic       m_ready, m_valid;
  int         m_cnt;
  logic [7:0] m_res;
  logic [3:0] m_flg;
  logic [11:0] m_pend;

  always @(posedge clk or posedge reset_n) begin : model
    logic rdy, vld;
    int cnt;
    logic [11:0] pend;
    if (reset_n) begin
      m_ready <= 1'b1; m_valid <= 1'b0; m_cnt <= 0;
      m_res <= '0; m_flg <= '0; m_pend <= '0;
    end else begin
      rdy = m_ready; vld = m_valid; cnt = m_cnt; pend = m_pend;
      if (vld) begin
        if (out_ready) begin vld = 1'b0; rdy = 1'b1; end
      end else if (rdy && in_valid) begin
        pend = ref_alu(op, a, b);
        cnt  = (op == 4'hE && b != 4'h0) ? W + 1 : 1;
        rdy  = 1'b0;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          vld = 1'b1;
          m_res <= pend[7:0];
          m_flg <= pend[11:8];
        end
      end
      m_ready <= rdy; m_valid <= vld; m_cnt <= cnt; m_pend <= pend;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model in_ready", 32'(in_ready), 32'(m_ready));
      chk("model out_valid", 32'(out_valid), 32'(m_valid));
      chk("model result", 32'(result), 32'(m_res));
      chk("model flags", 32'(flags), 32'(m_flg));
    end
  end

  task automatic send(input logic [3:0] o, input logic [3:0] x, input logic [3:0] y);
    int t = 0;
    while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) chk("send timeout", 32'(in_ready), 32'd1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic directed(input string nm, input logic [3:0] o, input logic [3:0] x,
                          input logic [3:0] y, input logic [11:0] exp, input int exp_lat);
    int lat = 1;
    send(o, x, y);
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " flags_result"}, 32'({flags, result}), 32'(exp));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, " in_ready after release"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    chk_en = 1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result", 32'(result), 32'd0);
    chk("reset flags", 32'(flags), 32'd0);

    chk("ref add 7+1", 32'(ref_alu(4'h1, 4'h7, 4'h1)), 32'h408);
    chk("ref mul -3*5", 32'(ref_alu(4'h6, 4'hD, 4'h5)), 32'h2F1);
    chk("ref div -7/2", 32'(ref_alu(4'hE, 4'h9, 4'h2)), 32'h2FD);
    chk("ref div 5/0", 32'(ref_alu(4'hE, 4'h5, 4'h0)), 32'hA5F);
    chk("ref div -8/-1", 32'(ref_alu(4'hE, 4'h8, 4'hF)), 32'h608);
    chk("ref gt 3>-2", 32'(ref_alu(4'hC, 4'h3, 4'hE)), 32'h001);

    directed("add", 4'h1, 4'h7, 4'h1, 12'h408, 1);
    directed("mul", 4'h6, 4'hD, 4'h5, 12'h2F1, 1);
    directed("div", 4'hE, 4'h9, 4'h2, 12'h2FD, 5);
    directed("dbz", 4'hE, 4'h5, 4'h0, 12'hA5F, 1);
    directed("divovf", 4'hE, 4'h8, 4'hF, 12'h608, 5);
    directed("sub", 4'h2, 4'h8, 4'h1, 12'h6F7, 1);
    directed("shr", 4'h8, 4'h8, 4'h0, 12'h2FC, 1);
    directed("undef", 4'hF, 4'h3, 4'h3, 12'h000, 1);

    // Backpressure: result held while a second request is presented
    send(4'hC, 4'h3, 4'hE);
    lat = 1;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("gt latency", 32'(lat), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op = 4'h1; a = 4'h1; b = 4'h1;
      chk("hold result", 32'(result), 32'h01);
      chk("hold flags", 32'(flags), 32'h0);
      chk("hold in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release in_ready", 32'(in_ready), 32'd1);
    chk("release out_valid", 32'(out_valid), 32'd0);

    // Reset in the second cycle of a divide
    send(4'hE, 4'h9, 4'h2);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    chk("midreset out_valid", 32'(out_valid), 32'd0);
    chk("midreset in_ready", 32'(in_ready), 32'd1);
    chk("midreset result", 32'(result), 32'd0);
    #1 reset_n = 1'b0;
    directed("add_after_reset", 4'h1, 4'h2, 4'h2, 12'h004, 1);

    // Randomized traffic, checked by the per-cycle compare
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 3) != 0;
      op        = ($urandom % 4 == 0) ? 4'hE : 4'($urandom % 16);
      a         = 4'($urandom);
      b         = ($urandom % 6 == 0) ? 4'h0 : 4'($urandom);
      if ($urandom % 16 == 0) begin a = 4'h8; b = 4'hF; end
      out_ready = 1'($urandom % 2);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle 4-bit ALU. Operand width is W bits, signed.
- Iterative multi-cycle signed divider, so division no longer sits in one combinational cycle.
- Result is 2W bits wide, plus a status-flag output.
- Sits between the UART command decoder (operand/opcode source) and the result latch/transmit path, using valid/ready on both sides.

Parameters:
- W, 4, operand width in bits (W >= 2).
- OPW, 4, opcode width.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-high (despite the name)
- in_valid  in  1  operand/opcode presented
- in_ready  out  1  block can accept a new operation
- op  in  OPW  operation select
- a  in  W  first operand, signed two's complement
- b  in  W  second operand, signed two's complement
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- result  out  2W  operation result
- flags  out  4  {dbz, ovf, neg, zero}

Behaviour:
- Reset (reset_n=1, asynchronous): state=IDLE, in_ready=1, out_valid=0, result=0, flags=0. Any in-flight division is discarded.
- States:
  - IDLE: in_ready=1. On in_valid, latch op, a and b. Op DIV goes to DIVIDE; all other ops compute into the result register and go to DONE.
  - DIVIDE: in_ready=0. Runs W iterations, one quotient bit per cycle, then goes to DONE.
  - DONE: out_valid=1. result and flags are held stable until out_ready=1, then go to IDLE. No new operation is accepted in the same cycle.
- Latency, from the accept edge to out_valid=1:
  - Non-divide ops: 1 cycle.
  - DIV: W+1 cycles.
  - Divide by zero: 1 cycle (DIVIDE is skipped).
- Opcodes (shared package). All arithmetic is signed. Operands are sign-extended to 2W unless stated otherwise.
  - ADD 0001: sext(a)+sext(b).
  - SUB 0010: sext(a)-sext(b).
  - AND 0011, OR 0100, XOR 0101: computed on W bits, result zero-extended.
  - MUL 0110: full signed 2W product.
  - SHL 0111: zero-extended a shifted left 1, on 2W bits.
  - SHR 1000: arithmetic right shift of a by 1, sign-extended.
  - NOT 1001: ~a on W bits, zero-extended.
  - EQ 1010, NE 1011, GT 1100, LT 1101: signed compares, result 1 or 0.
  - DIV 1110: result = {remainder[W-1:0], quotient[W-1:0]}. Quotient truncates toward zero; remainder takes the sign of a.
  - Undefined opcodes: result=0, flags=0, latency 1.
- Divider algorithm:
  - Convert a and b to magnitudes, run W-step restoring division, then apply the signs on the transition to DONE.
  - Most negative / -1 (e.g. -8/-1 at W=4): quotient wraps to the most negative value, ovf=1.
- Flags:
  - zero: result==0.
  - neg: the sign bit of the meaningful field. That is quotient[W-1] for DIV, result[2W-1] otherwise.
  - ovf: the W-bit signed result of ADD/SUB overflows, or the DIV overflow case above. 0 for all other ops.
  - dbz: DIV with b==0. It forces quotient to all ones, remainder to a, zero=0, neg=quotient[W-1]=1.
- Boundary conditions:
  - in_valid while in_ready=0: ignored. Upstream holds the request.
  - out_ready asserted while out_valid=0: no effect.
  - result and flags change only on the transition into DONE.

Decomposition:
- alu_pkg holds:
  - opcode localparams OP_ADD … OP_DIV;
  - flag bit indices FLG_ZERO=0, FLG_NEG=1, FLG_OVF=2, FLG_DBZ=3;
  - state encoding ST_IDLE, ST_DIVIDE, ST_DONE.
- One sub-module, alu_seq_div: parametrised by W. It has start/busy/done, takes unsigned magnitudes in and gives quotient/remainder out, with an internal iteration counter. The top level handles signs, flags and the handshake.

Test Plan (W=4):
- ADD a=7, b=1, out_ready=1 → out_valid one cycle after accept; result=0x08, flags ovf=1, neg=0, zero=0.
- MUL a=-3, b=5 → result=0xF1 (-15), neg=1, ovf=0, latency 1.
- DIV a=-7, b=2 → in_ready low for 4 cycles, out_valid at cycle 5; result=0xFD (rem -1, quo -3), neg=1.
- DIV a=5, b=0 → result=0x5F, dbz=1, latency 1. DIV a=-8, b=-1 → quotient 0x8, ovf=1.
- Backpressure: GT a=3, b=-2 with out_ready=0 for 5 cycles → result=0x01 held stable, in_ready=0 throughout. Single-cycle out_ready → IDLE on the next cycle.
- Reset pulse in the 2nd cycle of a DIV → out_valid=0, in_ready=1 and result=0 immediately. A following ADD 2+2 gives 0x04.
